stream_demux_router: RTL

Parametrised registered 1-to-N stream demultiplexer, the sequential successor to the team's combinational four-way demux cells. Routes each accepted input beat to one of CHANNELS output ports selected by `in_sel`, using a valid/ready handshake and a one-entry output register per channel. Optionally locks the route for a whole packet. Sits between a single producer and several independent consumers.

---
 rtl/stream_demux_router_if.sv | 28 ++
 rtl/stream_demux_router.sv | 100 ++++++++++
 2 files changed

// File: rtl/stream_demux_router_if.sv
// Stream demux bus: one producer side, CHANNELS consumer sides.
// Carries the input beat, its handshake and the flattened output channels.
interface stream_demux_router_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_last;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_last;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;

    modport master (
        output in_data, in_sel, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_valid
    );
endinterface

// File: rtl/stream_demux_router.sv
// Registered 1-to-N valid/ready stream demux, one output register per channel.
// Define DEMUX_PKT_LOCK_EN to hold the route for a whole packet.
module stream_demux_router #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_demux_router_if.slave  bus,
    output logic                  err_sel,
    output logic [7:0]            drop_cnt
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0]    data_q [CHANNELS];
    logic [CHANNELS-1:0] last_q;
    logic [CHANNELS-1:0] valid_q;
    logic [CHANNELS-1:0] free_v;
    logic [CHANNELS-1:0] load;
    logic [SEL_W-1:0]    dst;
    logic                dst_ok;
    logic                accept;

`ifdef DEMUX_PKT_LOCK_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [SEL_W-1:0] lock_sel;

    assign dst = (state == BUSY) ? lock_sel : bus.in_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= '0;
        end else if (accept) begin
            if (state == IDLE && !bus.in_last) begin
                state    <= BUSY;
                lock_sel <= bus.in_sel;
            end else if (state == BUSY && bus.in_last) begin
                state <= IDLE;
            end
        end
    end
`else
    assign dst = bus.in_sel;
`endif

    // A register can take a beat in the same cycle its consumer drains it.
    assign free_v       = ~valid_q | bus.out_ready;
    assign dst_ok       = (32'(dst) < CHANNELS);
    assign bus.in_ready = dst_ok ? free_v[dst] : 1'b1;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        load = '0;
        if (accept && dst_ok)
            load[dst] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '{default: '0};
            last_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k]) begin
                    data_q[k]  <= bus.in_data;
                    last_q[k]  <= bus.in_last;
                    valid_q[k] <= 1'b1;
                end else if (bus.out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < CHANNELS; k++)
            bus.out_data[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;

    // Beats aimed past the last channel are swallowed and counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= '0;
        end else if (accept && !dst_ok) begin
            err_sel <= 1'b1;
            if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule
